// File: rtl/cluster_packer_serial_if.sv
// Frame-in / packet-out bus of the serial cluster packer.
// master: S-bit deserialiser side (drives frames, reads packets); slave: the packer.
interface cluster_packer_serial_if #(
    parameter int MXSBITS    = 64,
    parameter int MXVFATS    = 24,
    parameter int MXCNTBITS  = 3,
    parameter int MXADRBITS  = 11,
    parameter int MXCLUSTERS = 8,
    parameter int MXNBITS    = 4
);
    localparam int MXCLSTBITS = MXCNTBITS + MXADRBITS;

    logic                               truncate_clusters;
    logic [MXVFATS*MXSBITS-1:0]         sbits_in;
    logic                               sbits_valid;
    logic                               busy;
    logic [MXCLUSTERS*MXCLSTBITS-1:0]   clusters_out;
    logic                               clusters_valid;
    logic [MXNBITS-1:0]                 cluster_count;
    logic                               overflow;
    logic                               frame_dropped;

    modport master (
        output truncate_clusters, sbits_in, sbits_valid,
        input  busy, clusters_out, clusters_valid, cluster_count, overflow, frame_dropped
    );

    modport slave (
        input  truncate_clusters, sbits_in, sbits_valid,
        output busy, clusters_out, clusters_valid, cluster_count, overflow, frame_dropped
    );
endinterface

// File: rtl/cluster_packer_serial.sv
// Serial chamber cluster packer: latches a frame, flags cluster starts and sizes
// per eta partition, then pulls out the lowest-address cluster once per clock and
// presents the finished packet with a fixed latency.
module cluster_packer_serial #(
    parameter int MXSBITS    = 64,
    parameter int MXVFATS    = 24,
    parameter int MXROWS     = 8,
    parameter int MXCNTBITS  = 3,
    parameter int MXADRBITS  = 11,
    parameter int MXCLUSTERS = 8,
    parameter int MXNBITS    = 4
) (
    input  logic                  clock4x,
    input  logic                  global_reset,
    cluster_packer_serial_if.slave bus
);
    localparam int NBITS   = MXVFATS * MXSBITS;
    localparam int ABITS   = $clog2(NBITS);
    localparam int MXKEYS  = NBITS / MXROWS;
    localparam int MAXSIZE = 2 ** MXCNTBITS;
    localparam int W       = MXCNTBITS + MXADRBITS;
    localparam int KBITS   = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1;
    localparam logic [W-1:0] INVALID_SLOT = {{MXCNTBITS{1'b0}}, {MXADRBITS{1'b1}}};

    typedef enum logic [1:0] {IDLE, FLAG, ENCODE, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   busy_c, valid_c, last_slot;

    logic [NBITS-1:0]       sbits_r, vpf_r, vpf_c, vpf_nxt;
    logic [MXCNTBITS-1:0]   cnt_r [NBITS];
    logic [MXCNTBITS-1:0]   cnt_c [NBITS];
    logic [W-1:0]           work_slot [MXCLUSTERS];
    logic [W-1:0]           out_slot  [MXCLUSTERS];
    logic [KBITS-1:0]       slot_idx;
    logic [MXNBITS-1:0]     fill_r, count_r;
    logic                   overflow_r, dropped_r;

    logic                   hit;
    logic [ABITS-1:0]       hit_idx;
    logic [MXCNTBITS-1:0]   hit_cnt;
    logic [W-1:0]           new_slot;
    logic [MXCLUSTERS*W-1:0] clusters_flat;

    assign last_slot = (state == ENCODE) && (slot_idx == KBITS'(MXCLUSTERS - 1));

    // State register.
    always_ff @(posedge clock4x) begin
        // NOTE: clocked blocks use <= so every register samples pre-edge values.
        if (global_reset) state <= IDLE;
        else              state <= state_nxt;
    end

    // Next state, busy and the one-cycle packet strobe.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_nxt = state;
        busy_c    = 1'b1;
        valid_c   = 1'b0;
        unique case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.sbits_valid) state_nxt = FLAG;
            end
            FLAG:    state_nxt = ENCODE;
            ENCODE:  if (last_slot) state_nxt = DONE;
            DONE: begin
                valid_c   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cluster-start flags and sizes for every key; rows never look across their edges.
    always_comb begin
        logic [ABITS-1:0]     a, am1, amx, aj;
        logic                 run;
        logic [MXCNTBITS-1:0] size;
        a    = '0;
        am1  = '0;
        amx  = '0;
        aj   = '0;
        run  = 1'b0;
        size = '0;
        vpf_c = '0;
        cnt_c = '{default: '0};
        for (int r = 0; r < MXROWS; r++) begin
            for (int key = 0; key < MXKEYS; key++) begin
                a   = ABITS'(r * MXKEYS + key);
                am1 = a - 1'b1;
                amx = a - ABITS'(MAXSIZE + 1);
                if (key == 0) begin
                    vpf_c[a] = sbits_r[a];
                end else begin
                    vpf_c[a] = sbits_r[a] & ~sbits_r[am1];
                    // One continuation start exactly MAXSIZE hits into a long run.
                    if (key > MAXSIZE && !bus.truncate_clusters)
                        vpf_c[a] = vpf_c[a] | (sbits_r[a] & (&sbits_r[am1 -: MAXSIZE]) & ~sbits_r[amx]);
                end
                run  = 1'b1;
                size = '0;
                for (int j = 1; j < MAXSIZE; j++) begin
                    aj = a + ABITS'(j);
                    if (run && (key + j < MXKEYS) && sbits_r[aj]) size = size + 1'b1;
                    else                                          run  = 1'b0;
                end
                cnt_c[a] = size;
            end
        end
    end

    // Lowest pending cluster start, its slot word, and the flags with it cleared.
    always_comb begin
        logic [ABITS-1:0] idx;
        idx     = '0;
        hit     = 1'b0;
        hit_idx = '0;
        hit_cnt = '0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            idx = ABITS'(i);
            if (vpf_r[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
                hit_cnt = cnt_r[idx];
            end
        end
        vpf_nxt = vpf_r;
        if (hit) vpf_nxt[hit_idx] = 1'b0;
        new_slot = hit ? {hit_cnt, MXADRBITS'(hit_idx)} : INVALID_SLOT;
    end

    // Frame, flag and working-slot storage.
    always_ff @(posedge clock4x) begin
        // NOTE: these arrays are deliberately not reset: each entry is rewritten before it is read.
        if (state == IDLE && bus.sbits_valid) sbits_r <= bus.sbits_in;
        if (state == FLAG) begin
            vpf_r <= vpf_c;
            cnt_r <= cnt_c;
        end else if (state == ENCODE) begin
            vpf_r               <= vpf_nxt;
            work_slot[slot_idx] <= new_slot;
        end
    end

    // Slot sequencing, drop detection and the held packet registers.
    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            slot_idx   <= '0;
            fill_r     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            dropped_r  <= 1'b0;
            for (int k = 0; k < MXCLUSTERS; k++) out_slot[k] <= INVALID_SLOT;
        end else begin
            dropped_r <= bus.sbits_valid && (state != IDLE);
            if (state == FLAG) begin
                slot_idx <= '0;
                fill_r   <= '0;
            end else if (state == ENCODE) begin
                slot_idx <= slot_idx + 1'b1;
                fill_r   <= fill_r + MXNBITS'(hit);
                if (last_slot) begin
                    for (int k = 0; k < MXCLUSTERS - 1; k++) out_slot[k] <= work_slot[k];
                    out_slot[MXCLUSTERS-1] <= new_slot;
                    count_r                <= fill_r + MXNBITS'(hit);
                    overflow_r             <= |vpf_nxt;
                end
            end
        end
    end

    // Flatten the held slots onto the packet bus.
    always_comb begin
        clusters_flat = '0;
        for (int k = 0; k < MXCLUSTERS; k++) clusters_flat[k*W +: W] = out_slot[k];
    end

    assign bus.busy           = busy_c;
    assign bus.clusters_valid = valid_c;
    assign bus.clusters_out   = clusters_flat;
    assign bus.cluster_count  = count_r;
    assign bus.overflow       = overflow_r;
    assign bus.frame_dropped  = dropped_r;
endmodule
